// File: rtl/a2d_arbiter.sv
// a2d_arbiter: round-robin sharing of one A2D SPI converter among three
// requesters (0 = IR sweep, 1 = battery, 2 = motor current). The winner's
// channel is latched, one conversion is issued, and the result goes back
// to the winner. A watchdog ends a conversion that never completes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; arbitrate among req starting at ptr
// ISSUE | winner latched; a2d_strt_cnv high for this one cycle; tmr cleared
// WAIT  | conversion in flight; finish on a2d_cnv_cmplt or watchdog expiry
module a2d_arbiter #(
  parameter int TMO_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [2:0]  chnnl0,
  input  logic [2:0]  chnnl1,
  input  logic [2:0]  chnnl2,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        err,
  output logic [11:0] res,
  output logic        a2d_strt_cnv,
  output logic [2:0]  a2d_chnnl,
  input  logic        a2d_cnv_cmplt,
  input  logic [11:0] a2d_res
);

  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [2:0]    chnnl_q, chnnl_d;
  logic [11:0]   res_q, res_d;
  logic [2:0]    done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic [1:0]    pick_idx;
  logic [2:0]    pick_chnnl;
  logic [1:0]    win_idx;
  logic [1:0]    ptr_after;

  // First requester with req set, searching ptr, ptr+1, ptr+2 (mod 3).
  // ptr only ever holds 0..2, so the rotation never sees index 3.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] a, b, c;
    a = p;
    b = (a == 2'd2) ? 2'd0 : a + 2'd1;
    c = (b == 2'd2) ? 2'd0 : b + 2'd1;
    if (r[a])      pick = a;
    else if (r[b]) pick = b;
    else           pick = c;
  endfunction

  // Arbitration winner and its channel; current owner index and the pointer after it.
  always_comb begin
    pick_idx = pick(req, ptr_q);
    case (pick_idx)
      2'd0:    pick_chnnl = chnnl0;
      2'd1:    pick_chnnl = chnnl1;
      default: pick_chnnl = chnnl2;
    endcase
    if (gnt_q[2])      win_idx = 2'd2;
    else if (gnt_q[1]) win_idx = 2'd1;
    else               win_idx = 2'd0;
    ptr_after = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
  end

  // Next-state and next-register computation; done/err default to 0 so they pulse.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    chnnl_d = chnnl_q;
    res_d   = res_q;
    done_d  = 3'b000;
    err_d   = 1'b0;
    ptr_d   = ptr_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = 3'b001 << pick_idx;
          chnnl_d = pick_chnnl;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmr_d = tmr_q + 1'b1;
        // completion takes priority over a watchdog expiry in the same cycle
        if (a2d_cnv_cmplt) begin
          res_d   = a2d_res;
          done_d  = gnt_q;
          gnt_d   = 3'b000;
          ptr_d   = ptr_after;
          state_d = IDLE;
        end else if (tmr_q == TMO_LAST) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          gnt_d   = 3'b000;
          ptr_d   = ptr_after;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      chnnl_q <= 3'b000;
      res_q   <= 12'h000;
      done_q  <= 3'b000;
      err_q   <= 1'b0;
      ptr_q   <= 2'd0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      chnnl_q <= chnnl_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      tmr_q   <= tmr_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign err          = err_q;
  assign res          = res_q;
  assign a2d_chnnl    = chnnl_q;
  assign a2d_strt_cnv = (state_q == ISSUE);

endmodule

// File: tb/tb_a2d_arbiter.sv
// Bench for a2d_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level model (round-robin
// pointer plus last result) with cycle-exact expectations.
module tb_a2d_arbiter;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  chnnl0 = 3'd0, chnnl1 = 3'd0, chnnl2 = 3'd0;
  logic        a2d_cnv_cmplt = 1'b0;
  logic [11:0] a2d_res = 12'h000;
  logic [2:0]  gnt, done, a2d_chnnl;
  logic        err, a2d_strt_cnv;
  logic [11:0] res;

  int total = 0;
  int bad = 0;
  int mptr = 0;
  logic [11:0] mres = 12'h000;

  a2d_arbiter #(.TMO_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .chnnl0(chnnl0), .chnnl1(chnnl1), .chnnl2(chnnl2),
    .gnt(gnt), .done(done), .err(err), .res(res),
    .a2d_strt_cnv(a2d_strt_cnv), .a2d_chnnl(a2d_chnnl),
    .a2d_cnv_cmplt(a2d_cnv_cmplt), .a2d_res(a2d_res)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    req = 3'b000;
    a2d_cnv_cmplt = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    mptr = 0;
    mres = 12'h000;
  endtask

  // One complete transaction. lat = WAIT cycles before completion is driven,
  // or -1 to let the watchdog fire.
  task automatic run_txn(input logic [2:0] r, input logic [2:0] c0, input logic [2:0] c1,
                         input logic [2:0] c2, input logic [11:0] rv, input int lat,
                         input bit drop, input bit stale_issue);
    int w, ri, idx;
    logic [2:0] oh, ch;
    w = -1;
    ri = int'(r);
    for (int k = 0; k < 3; k++) begin
      idx = (mptr + k) % 3;
      if (w < 0 && ((ri >> idx) & 1) == 1) w = idx;
    end
    oh = 3'(1 << w);
    ch = (w == 0) ? c0 : (w == 1) ? c1 : c2;

    req = r; chnnl0 = c0; chnnl1 = c1; chnnl2 = c2;
    tick;
    chk("grant", 32'(gnt), 32'(oh));
    chk("grant_chnnl", 32'(a2d_chnnl), 32'(ch));
    chk("strt_pulse", 32'(a2d_strt_cnv), 32'd1);
    chk("done_quiet", 32'(done), 32'd0);
    chnnl0 = ~c0; chnnl1 = ~c1; chnnl2 = ~c2;
    if (stale_issue) begin
      a2d_cnv_cmplt = 1'b1;
      a2d_res = ~rv;
    end
    tick;
    a2d_cnv_cmplt = 1'b0;
    if (drop) req = 3'b000;
    chk("wait_hold", 32'({gnt, a2d_chnnl, a2d_strt_cnv, done, err}), 32'({oh, ch, 1'b0, 3'b000, 1'b0}));
    if (lat < 0) begin
      for (int k = 1; k < T; k++) begin
        tick;
        chk("wd_hold", 32'({gnt, a2d_chnnl, a2d_strt_cnv, done, err}), 32'({oh, ch, 1'b0, 3'b000, 1'b0}));
      end
      tick;
      chk("wd_done", 32'(done), 32'(oh));
      chk("wd_err", 32'(err), 32'd1);
      chk("wd_res_held", 32'(res), 32'(mres));
      chk("wd_gnt_clear", 32'(gnt), 32'd0);
    end else begin
      for (int k = 0; k < lat; k++) begin
        tick;
        chk("cnv_hold", 32'({gnt, a2d_chnnl, a2d_strt_cnv, done, err}), 32'({oh, ch, 1'b0, 3'b000, 1'b0}));
      end
      a2d_cnv_cmplt = 1'b1;
      a2d_res = rv;
      tick;
      a2d_cnv_cmplt = 1'b0;
      a2d_res = 12'($urandom);
      chk("cnv_done", 32'(done), 32'(oh));
      chk("cnv_err", 32'(err), 32'd0);
      chk("cnv_res", 32'(res), 32'(rv));
      chk("cnv_gnt_clear", 32'(gnt), 32'd0);
      mres = rv;
    end
    mptr = (w + 1) % 3;
    req = 3'b000;
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    tick;
    tick;
    chk("rst_outputs", 32'({gnt, done, err, res, a2d_strt_cnv, a2d_chnnl}), 32'd0);
    rst_n = 1'b1;

    // single request on requester 1
    run_txn(3'b010, 3'd0, 3'd5, 3'd0, 12'hA5C, 3, 1'b0, 1'b0);
    tick;
    chk("single_done_one_cycle", 32'(done), 32'd0);

    // round robin from a fresh pointer, all requesters held
    do_reset;
    for (int n = 0; n < 6; n++)
      run_txn(3'b111, 3'($urandom), 3'($urandom), 3'($urandom), 12'($urandom),
              int'($urandom_range(0, 5)), 1'b0, 1'b0);

    // watchdog, then a normal transaction
    run_txn(3'b100, 3'd3, 3'd4, 3'd6, 12'h777, -1, 1'b0, 1'b0);
    run_txn(3'b001, 3'd2, 3'd1, 3'd7, 12'h3C3, 1, 1'b0, 1'b0);

    // stale completion in IDLE
    a2d_cnv_cmplt = 1'b1;
    a2d_res = 12'hBAD;
    tick;
    a2d_cnv_cmplt = 1'b0;
    tick;
    chk("stale_idle_done", 32'(done), 32'd0);
    chk("stale_idle_res", 32'(res), 32'(mres));

    // stale completion in ISSUE, then completion coincident with watchdog
    run_txn(3'b011, 3'd1, 3'd6, 3'd2, 12'h5A5, 2, 1'b0, 1'b1);
    run_txn(3'b110, 3'd7, 3'd3, 3'd5, 12'hE01, T - 1, 1'b0, 1'b0);

    // requester 0 drops its request mid-transaction; pointer then moves to 1
    run_txn(3'b001, 3'd4, 3'd2, 3'd1, 12'h0F0, 4, 1'b1, 1'b0);
    run_txn(3'b111, 3'd0, 3'd6, 3'd3, 12'h123, 0, 1'b0, 1'b0);
    chk("drop_ptr_advanced", 32'(mptr), 32'd2);

    // reset in the middle of WAIT
    req = 3'b100;
    tick;
    tick;
    req = 3'b000;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("midrst_outputs", 32'({gnt, done, err, res, a2d_strt_cnv, a2d_chnnl}), 32'd0);
    mptr = 0;
    mres = 12'h000;
    a2d_cnv_cmplt = 1'b1;
    a2d_res = 12'hFFF;
    tick;
    a2d_cnv_cmplt = 1'b0;
    tick;
    chk("midrst_late_cmplt_done", 32'(done), 32'd0);
    chk("midrst_late_cmplt_res", 32'(res), 32'd0);
    run_txn(3'b110, 3'd1, 3'd2, 3'd3, 12'h456, 2, 1'b0, 1'b0);

    // randomized transactions with idle gaps
    for (int n = 0; n < 40; n++) begin
      int gap, lat;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick;
      lat = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, T - 1));
      run_txn(3'($urandom_range(1, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
              12'($urandom), lat, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a2d_arbiter.md
# a2d_arbiter

Round-robin arbiter and sequencer that shares the single A2D SPI converter (A2D_intf) among three requesters: IR sensor sweep, battery monitor and motor-current monitor. It sits between the requesters and A2D_intf. It latches the winner's channel, issues one conversion, returns the 12-bit result to the winner, and recovers from a hung conversion with a watchdog.

## Interface
- TMO_CYCLES, default 4096: watchdog limit in clk cycles between strt_cnv and cnv_cmplt; must be > worst-case conversion time.
- clk  in  1  system clock; all logic is posedge clk.
- rst_n  in  1  reset, synchronous, active-low; one clock, and reset is synchronous and active-low.
- req  in  3  per-requester conversion request, level; bit 0 = IR, 1 = battery, 2 = current.
- chnnl0, chnnl1, chnnl2  in  3 each  channel requested by requester 0/1/2; sampled only on grant.
- gnt  out  3  one-hot grant, held from grant cycle to completion cycle.
- done  out  3  one-hot, one-cycle pulse to the winner when its transaction ends.
- err  out  1  one-cycle pulse coincident with done when the transaction ended by watchdog.
- res  out  12  result register; valid with done, held until the next done.
- a2d_strt_cnv  out  1  start pulse to A2D_intf.
- a2d_chnnl  out  3  registered channel to A2D_intf, stable for the whole transaction.
- a2d_cnv_cmplt  in  1  completion pulse from A2D_intf.
- a2d_res  in  12  result from A2D_intf, valid with a2d_cnv_cmplt.

## Operation
- State machine has three states: IDLE, ISSUE, WAIT.
- Registers: state, gnt, a2d_chnnl, res, done, err, 2-bit round-robin pointer ptr (0..2), watchdog counter tmr with width clog2(TMO_CYCLES).
- IDLE: if any req bit is set, select the first set bit searching ptr, ptr+1, ptr+2 (mod 3).
  - Load gnt with the winner's one-hot, load a2d_chnnl with that requester's chnnl, and go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE: a2d_strt_cnv = 1 (Moore output, exactly one cycle); clear tmr; go to WAIT.
- WAIT: tmr increments each cycle.
  - On a2d_cnv_cmplt: res <= a2d_res; done <= gnt; gnt <= 0; ptr <= winner+1 (mod 3); go to IDLE.
  - Else, if tmr == TMO_CYCLES-1: done <= gnt; err <= 1; res unchanged; gnt <= 0; ptr <= winner+1; go to IDLE.
  - If a2d_cnv_cmplt and the timeout coincide, completion wins and err stays 0.
- a2d_cnv_cmplt in IDLE or ISSUE is stale and is ignored; no state or output change.
- req is not re-sampled while gnt is nonzero. Dropping req mid-transaction does not abort it, and done still pulses to that requester.
- The requester's chnnl may change after the grant cycle without effect.
- Reset (rst_n = 0 at a posedge) forces the following, regardless of state or an in-flight conversion:
  - state = IDLE, ptr = 0, gnt = 0, done = 0, err = 0, a2d_strt_cnv = 0, a2d_chnnl = 0, res = 12'h000, tmr = 0.

## Timing
- req sampled set in IDLE at cycle t:
  - gnt and a2d_chnnl valid at t+1, and a2d_strt_cnv = 1 during t+1.
  - WAIT from t+2.
- a2d_cnv_cmplt high at cycle c in WAIT:
  - done, res and ptr update at c+1; gnt = 0 at c+1; state IDLE at c+1.
  - Earliest next grant is c+2, so there is one idle cycle minimum between transactions.
- Watchdog: err/done assert TMO_CYCLES+1 cycles after the a2d_strt_cnv cycle if no completion arrives.
- Fairness: with all three req held high, grant order is 0,1,2,0,... and no requester waits more than two transactions.

## Test plan
- Single request: after reset, req = 3'b010, chnnl1 = 3'd5, A2D returns 12'hA5C.
  - Required: gnt = 3'b010 one cycle later, a2d_chnnl = 5, a single strt_cnv pulse, then done = 3'b010 with res = 12'hA5C and err = 0.
- Round-robin: req = 3'b111 held for 6 transactions.
  - Required: grant sequence 001, 010, 100, 001, 010, 100, each with its own chnnlN on a2d_chnnl.
- Watchdog: TMO_CYCLES = 16, never assert a2d_cnv_cmplt.
  - Required: done and err pulse 17 cycles after strt_cnv, res holds its previous value, and the next request is served normally.
- Stale and coincident completion:
  - a2d_cnv_cmplt pulsed in IDLE and in ISSUE causes no done.
  - In WAIT, cnv_cmplt at tmr == TMO_CYCLES-1 gives done with err = 0 and res updated.
- Request drop: req[0] deasserted mid-WAIT.
  - Required: transaction completes, done = 3'b001, and ptr advances to 1.
- Mid-operation reset: rst_n low for 1 cycle during WAIT.
  - Required: all outputs are 0 on the next cycle, ptr = 0, and a later a2d_cnv_cmplt is ignored.
  - Required: with req = 3'b110, the first grant after reset is 3'b010.
